noc_channel_arbiter: RTL



---
 rtl/noc_channel_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/noc_channel_arbiter.sv
// noc_channel_arbiter: packet-granular round-robin arbiter sharing one NoC
// output link between CHANNELS input flit streams. A channel that wins keeps
// the link until its last flit transfers, so packets never interleave.
// Optional build macro NOC_ARB_OUTREG_EN adds a registered output stage
// (one cycle of latency, full throughput); the default build is a
// combinational mux with out_ready feeding in_ready directly.
module noc_channel_arbiter #(
  parameter  int FLIT_WIDTH = 32,
  parameter  int CHANNELS   = 2,
  localparam int CW         = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CW-1:0]                  out_channel,
  output logic                           busy
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         prio_q, prio_d;
  logic [CW-1:0]         lock_q, lock_d;
  logic [CW-1:0]         win_idx, sel;
  logic [CW:0]           idx_ext;
  logic                  win_found, sel_ok, sel_vld, sel_last;
  logic                  can_accept, fire;
  logic [FLIT_WIDTH-1:0] sel_flit;

  function automatic logic [CW-1:0] next_ptr(input logic [CW-1:0] p);
    return (p == CW'(CHANNELS - 1)) ? '0 : p + CW'(1);
  endfunction

  // FSM state, priority pointer and lock registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
    end
  end

  // Round-robin search starting at prio_q, wrapping explicitly at CHANNELS
  always_comb begin
    win_found = 1'b0;
    win_idx   = prio_q;
    idx_ext   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx_ext = {1'b0, prio_q} + (CW+1)'(k);
      if (idx_ext >= (CW+1)'(CHANNELS)) idx_ext = idx_ext - (CW+1)'(CHANNELS);
      if (!win_found && in_valid[idx_ext[CW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_ext[CW-1:0];
      end
    end
  end

  // Select the connected channel and steer ready back to it only
  always_comb begin
    sel      = (state_q == BUSY) ? lock_q : win_idx;
    sel_ok   = (state_q == BUSY) || win_found;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_flit = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel_ok && (sel == CW'(i))) begin
        sel_vld     = in_valid[i];
        sel_last    = in_last[i];
        sel_flit    = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        in_ready[i] = can_accept;
      end
    end
    fire = sel_vld && can_accept;
  end

  // Next-state: lock on a non-last first flit, advance prio past a finished packet
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (sel_last) begin
            prio_d = next_ptr(win_idx);
          end else begin
            lock_d  = win_idx;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (fire && sel_last) begin
          prio_d  = next_ptr(lock_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output
  always_comb begin
    busy = (state_q == BUSY);
  end

`ifdef NOC_ARB_OUTREG_EN
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [CW-1:0]         chan_q, chan_d;

  // Output stage accepts whenever it is empty or draining this cycle
  always_comb begin
    can_accept  = !rst && (!out_valid_q || out_ready);
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    chan_d      = chan_q;
    if (fire) begin
      out_flit_d  = sel_flit;
      out_last_d  = sel_last;
      out_valid_d = 1'b1;
      chan_d      = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      chan_q      <= '0;
    end else begin
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      chan_q      <= chan_d;
    end
  end

  // Drive ports from the output stage
  always_comb begin
    out_flit    = out_flit_q;
    out_last    = out_last_q;
    out_valid   = out_valid_q;
    out_channel = chan_q;
  end
`else
  logic [CW-1:0] chan_q, chan_d;

  // Combinational path; out_channel holds its last value while idle
  always_comb begin
    can_accept  = !rst && out_ready;
    out_flit    = sel_flit;
    out_last    = sel_last;
    out_valid   = sel_vld && !rst;
    out_channel = out_valid ? sel : chan_q;
    chan_d      = out_channel;
  end

  // Remember the last driving channel
  always_ff @(posedge clk) begin
    if (rst) chan_q <= '0;
    else     chan_q <= chan_d;
  end
`endif

endmodule
